// File: rtl/union_reg_pkg.sv
// Shared types for the union register arbiter: the 32-bit packed union, the
// owner encodings and the arbitration FSM states.
package union_reg_pkg;

    typedef struct packed {
        logic [15:0] data1;
        logic [15:0] data2;
    } data_member;

    // Nibbles 7..4 overlay data1 and nibbles 3..0 overlay data2.
    typedef union packed {
        data_member      op1;
        logic [7:0][3:0] op_2;
    } union_s1;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_A    = 2'b01,
        OWN_B    = 2'b10
    } owner_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACK_A = 2'b01,
        S_ACK_B = 2'b10
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on contention the requester that was not
// granted last wins. Grant is one-hot: bit 0 = A, bit 1 = B.
module rr_arb2 (
    input  logic       i_req_a,
    input  logic       i_req_b,
    input  logic       i_rr_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_req_a && i_req_b) begin
            o_grant = i_rr_last ? 2'b01 : 2'b10;
        end else if (i_req_a) begin
            o_grant = 2'b01;
        end else if (i_req_b) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/union_reg_arbiter.sv
// Arbitrates a half-word requester (A) and a nibble requester (B) onto one
// shared 32-bit union register; free-running steps advance it when idle.
module union_reg_arbiter
    import union_reg_pkg::*;
#(
    parameter int STEP1 = 5,
    parameter int STEP2 = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic        a_sel,
    input  logic        a_add,
    input  logic [15:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [2:0]  b_idx,
    input  logic [3:0]  b_nib,
    input  logic        tick_en,
    output union_s1     word,
    output logic [1:0]  owner
);

    localparam logic [15:0] STEP1_W = 16'(STEP1);
    localparam logic [15:0] STEP2_W = 16'(STEP2);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_rr_last;
    union_s1    r_word;
    union_s1    w_word_nxt;
    logic [1:0] w_grant;

    rr_arb2 u_rr_arb2 (
        .i_req_a   (a_valid),
        .i_req_b   (b_valid),
        .i_rr_last (r_rr_last),
        .o_grant   (w_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr_last <= 1'b1;
            r_word    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            if (r_state == S_ACK_A) begin
                r_rr_last <= 1'b0;
            end else if (r_state == S_ACK_B) begin
                r_rr_last <= 1'b1;
            end
        end
    end

    // Any pending request suppresses the idle step for that cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        case (r_state)
            S_IDLE: begin
                if (w_grant[0]) begin
                    w_state_nxt = S_ACK_A;
                end else if (w_grant[1]) begin
                    w_state_nxt = S_ACK_B;
                end else if (tick_en) begin
                    w_word_nxt.op1.data1 = r_word.op1.data1 + STEP1_W;
                    w_word_nxt.op1.data2 = r_word.op1.data2 + STEP2_W;
                end
            end
            S_ACK_A: begin
                w_state_nxt = S_IDLE;
                if (a_sel) begin
                    w_word_nxt.op1.data2 = a_add ? (r_word.op1.data2 + a_data) : a_data;
                end else begin
                    w_word_nxt.op1.data1 = a_add ? (r_word.op1.data1 + a_data) : a_data;
                end
            end
            S_ACK_B: begin
                w_state_nxt           = S_IDLE;
                w_word_nxt.op_2[b_idx] = b_nib;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign a_ready = (r_state == S_ACK_A);
    assign b_ready = (r_state == S_ACK_B);
    assign owner   = (r_state == S_ACK_A) ? OWN_A :
                     (r_state == S_ACK_B) ? OWN_B : OWN_IDLE;
    assign word    = r_word;

endmodule

// File: tb/tb_union_reg_arbiter.sv
// Directed bench for union_reg_arbiter: a transfer table plus hand-written
// reset, stepping, contention and precedence sequences.
module tb_union_reg_arbiter;
    import union_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic        a_sel = 1'b0;
    logic        a_add = 1'b0;
    logic [15:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [2:0]  b_idx = '0;
    logic [3:0]  b_nib = '0;
    logic        tick_en = 1'b0;
    union_s1     word;
    logic [1:0]  owner;

    int n_chk  = 0;
    int n_fail = 0;

    union_reg_arbiter #(.STEP1(5), .STEP2(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_sel   (a_sel),
        .a_add   (a_add),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_idx   (b_idx),
        .b_nib   (b_nib),
        .tick_en (tick_en),
        .word    (word),
        .owner   (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_b;
        logic        sel;
        logic        add;
        logic [15:0] data;
        logic [2:0]  idx;
        logic [3:0]  nib;
        logic [31:0] exp_word;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One handshake: raise valid, wait (bounded) for ready, then check commit.
    task automatic xfer(input vec_t v, input string nm);
        int lat;
        lat = 0;
        a_sel  = v.sel;
        a_add  = v.add;
        a_data = v.data;
        b_idx  = v.idx;
        b_nib  = v.nib;
        if (v.is_b) b_valid = 1'b1;
        else        a_valid = 1'b1;
        do begin
            tick();
            lat++;
        end while (!(v.is_b ? b_ready : a_ready) && lat < 4);
        chk({nm, "_latency"}, lat, 1);
        chk({nm, "_owner"}, {30'd0, owner}, v.is_b ? 32'd2 : 32'd1);
        chk({nm, "_other_ready"}, {31'd0, v.is_b ? a_ready : b_ready}, 0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        chk({nm, "_word"}, word, v.exp_word);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'hABCD, 3'd0, 4'h0, 32'hABCD_0000};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 16'h0034, 3'd0, 4'h0, 32'hAC01_0000};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 4'h0, 32'hAC01_0000};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 3'd1, 4'h1, 32'hAC01_0010};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 3'd2, 4'h2, 32'hAC01_0210};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 3'd3, 4'h3, 32'hAC01_3210};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 3'd4, 4'h4, 32'hAC04_3210};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 3'd5, 4'h5, 32'hAC54_3210};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 3'd6, 4'h6, 32'hA654_3210};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 3'd7, 4'h7, 32'h7654_3210};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 3'd7, 4'hF, 32'hF654_3210};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 3'd0, 4'h0, 32'hF654_320F};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h5678, 3'd0, 4'h0, 32'hF654_5678};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h1234, 3'd0, 4'h0, 32'h1234_5678};

        // Reset state
        #1;
        chk("rst_word", word, 32'h0);
        chk("rst_owner", {30'd0, owner}, 0);
        chk("rst_ready", {30'd0, a_ready, b_ready}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            xfer(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset asserted during an ACK cycle aborts the transfer
        a_sel = 1'b0; a_add = 1'b0; a_data = 16'h9999; a_valid = 1'b1;
        tick();
        chk("midack_ready_before", {31'd0, a_ready}, 1);
        rst = 1'b1;
        #1;
        chk("midack_ready", {30'd0, a_ready, b_ready}, 0);
        chk("midack_owner", {30'd0, owner}, 0);
        chk("midack_word", word, 32'h0);
        a_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("midack_no_commit", word, 32'h0);

        // Contention right after reset: A first, then alternate
        a_sel = 1'b0; a_add = 1'b0; a_data = 16'h1111;
        b_idx = 3'd0; b_nib = 4'h5;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [1:0] e;
            tick();
            e = (k % 2 == 1) ? 2'd0 : ((k % 4 == 0) ? 2'd1 : 2'd2);
            chk($sformatf("cont%0d_owner", k), {30'd0, owner}, {30'd0, e});
            chk($sformatf("cont%0d_ready", k), {30'd0, b_ready, a_ready}, {30'd0, e});
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("cont_word", word, 32'h1111_0005);

        // Precedence: a pending request blocks ticks; stepping resumes after
        tick_en = 1'b1;
        a_sel = 1'b1; a_add = 1'b0; a_data = 16'h0100; a_valid = 1'b1;
        tick();
        chk("prec_req_no_tick", word, 32'h1111_0005);
        a_valid = 1'b0;
        tick();
        chk("prec_commit", word, 32'h1111_0100);
        tick();
        chk("prec_resume", word, 32'h1116_0106);
        tick_en = 1'b0;

        // Idle stepping from zero, then wrap of data1 without carry
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick_en = 1'b1;
        repeat (10) tick();
        tick_en = 1'b0;
        chk("step10", word, 32'h0032_003C);
        xfer('{1'b0, 1'b0, 1'b0, 16'hFFFE, 3'd0, 4'h0, 32'hFFFE_003C}, "pre_d1");
        xfer('{1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 4'h0, 32'hFFFE_0000}, "pre_d2");
        tick_en = 1'b1;
        tick();
        tick_en = 1'b0;
        chk("wrap_data1", {16'd0, word.op1.data1}, 32'h0003);
        chk("wrap_data2", {16'd0, word.op1.data2}, 32'h0006);
        tick();
        chk("hold_no_tick", word, 32'h0003_0006);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
